// File: rtl/counter_run_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_run_controller_if
// Brief    : Control/status bundle between system logic and the run sequencer.
// Revision : 1.0
// ============================================================================
interface counter_run_controller_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] target;
  logic             abort;
  logic [WIDTH-1:0] q_in;
  logic             cnt_reset;
  logic             ready;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, target, abort, q_in,
    input  cnt_reset, ready, busy, done, err
  );

  modport slave (
    input  start, target, abort, q_in,
    output cnt_reset, ready, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/counter_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : counter_run_controller
// Brief    : Clears, releases and watches an external counter until it reaches
//            a latched target; optional RUN timeout via COUNTER_RUN_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module counter_run_controller #(
  parameter int WIDTH        = 4,
  parameter int CLEAR_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  wire logic             clk,
  input  wire logic             reset,
  counter_run_controller_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int             CW         = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES + 1) : 1;
  localparam logic [CW-1:0]  C_CLR_LAST = CW'(CLEAR_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_target, w_target_nxt;
  logic [CW-1:0]    r_clr_cnt, w_clr_cnt_nxt;
  logic             r_cnt_reset, w_cnt_reset_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_match;

`ifdef COUNTER_RUN_TIMEOUT_EN
  localparam int            RW        = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] C_RUN_MAX = RW'(TIMEOUT);

  logic [RW-1:0] r_run_cnt, w_run_cnt_nxt;
  logic          r_err, w_err_nxt;
`else
  // TIMEOUT only has meaning in the timeout build.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  assign w_match = (bus.q_in == r_target);

  always_comb begin
    w_state_nxt     = r_state;
    w_target_nxt    = r_target;
    w_clr_cnt_nxt   = r_clr_cnt;
    w_cnt_reset_nxt = 1'b1;
    w_ready_nxt     = 1'b0;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
`ifdef COUNTER_RUN_TIMEOUT_EN
    w_run_cnt_nxt   = r_run_cnt;
    w_err_nxt       = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt   = S_CLEAR;
          w_target_nxt  = bus.target;
          w_clr_cnt_nxt = '0;
          w_busy_nxt    = 1'b1;
        end else begin
          w_ready_nxt   = 1'b1;
        end
      end
      S_CLEAR: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_ready_nxt = 1'b1;
        end else if (r_clr_cnt == C_CLR_LAST) begin
          w_state_nxt     = S_RUN;
          w_cnt_reset_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
`ifdef COUNTER_RUN_TIMEOUT_EN
          w_run_cnt_nxt   = '0;
`endif
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + CW'(1);
          w_busy_nxt    = 1'b1;
        end
      end
      S_RUN: begin
        // Abort outranks a match (and expiry) on the same edge.
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_ready_nxt = 1'b1;
        end else if (w_match) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
`ifdef COUNTER_RUN_TIMEOUT_EN
        end else if (r_run_cnt == C_RUN_MAX) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
        end else begin
          w_run_cnt_nxt   = r_run_cnt + RW'(1);
          w_cnt_reset_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
        end
`else
        end else begin
          w_cnt_reset_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
        end
`endif
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_target    <= '0;
      r_clr_cnt   <= '0;
      r_cnt_reset <= 1'b1;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_target    <= w_target_nxt;
      r_clr_cnt   <= w_clr_cnt_nxt;
      r_cnt_reset <= w_cnt_reset_nxt;
      r_ready     <= w_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

`ifdef COUNTER_RUN_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_run_cnt <= w_run_cnt_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.cnt_reset = r_cnt_reset;
  assign bus.ready     = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_counter_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_run_controller
// Brief    : Directed and random stimulus against a latency-based model.
// Revision : 1.0
// ============================================================================
module tb_counter_run_controller;
  localparam int WIDTH        = 4;
  localparam int CLEAR_CYCLES = 2;
  localparam int TIMEOUT      = 8;

  logic clk = 1'b0;
  logic reset;
  logic freeze;
  always #5 clk = ~clk;

  counter_run_controller_if #(.WIDTH(WIDTH)) bus ();

  counter_run_controller #(
    .WIDTH(WIDTH), .CLEAR_CYCLES(CLEAR_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Counter being sequenced: sync reset, +1 per edge unless frozen.
  always @(posedge clk) begin
    if (bus.cnt_reset)  bus.q_in <= '0;
    else if (!freeze)   bus.q_in <= bus.q_in + 1'b1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Model: 0 idle, 1 busy, 2 done; m_e counts edges since the accept edge.
  int m_mode = 0;
  int m_e    = 0;
  int m_tgt  = 0;
  int m_done_at = 0;
  bit m_err  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic [WIDTH-1:0] t, input logic a, input logic r);
    logic [WIDTH-1:0] q_pre;
    int lim;
    bus.start  = s;
    bus.target = t;
    bus.abort  = a;
    reset      = r;
    q_pre      = bus.q_in;
    @(posedge clk);
    if (r) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (s) begin
          m_mode = 1;
          m_e    = 0;
          m_tgt  = int'(t);
          lim    = (freeze && t != 0) ? 1000 : int'(t);
`ifdef COUNTER_RUN_TIMEOUT_EN
          if (lim > TIMEOUT) begin
            m_done_at = CLEAR_CYCLES + 1 + TIMEOUT;
            m_err     = 1;
          end else begin
            m_done_at = CLEAR_CYCLES + 1 + lim;
            m_err     = 0;
          end
`else
          m_done_at = CLEAR_CYCLES + 1 + lim;
          m_err     = 0;
`endif
        end
        1: begin
          m_e++;
          if (a) m_mode = 0;
          else if (m_e == m_done_at) begin
            m_mode = 2;
            if (!m_err) check("q_at_match", 32'(q_pre), 32'(m_tgt));
          end
        end
        default: m_mode = 0;
      endcase
    end
    #1;
    check("ready",     32'(bus.ready),     32'(m_mode == 0));
    check("busy",      32'(bus.busy),      32'(m_mode == 1));
    check("done",      32'(bus.done),      32'(m_mode == 2));
    check("err",       32'(bus.err),       32'(m_mode == 2 && m_err));
    check("cnt_reset", 32'(bus.cnt_reset), 32'(!(m_mode == 1 && m_e >= CLEAR_CYCLES)));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    freeze = 1'b0;
    bus.start = 1'b0; bus.target = '0; bus.abort = 1'b0; reset = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);

    step(1'b1, 4'd5, 1'b0, 1'b0);  idle_steps(12);
    step(1'b1, 4'd0, 1'b0, 1'b0);  idle_steps(6);
    step(1'b1, 4'd15, 1'b0, 1'b0); idle_steps(22);

    step(1'b1, 4'd9, 1'b0, 1'b0);
    idle_steps(3);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    idle_steps(14);

    // Start held and target changed while busy must not disturb the run.
    step(1'b1, 4'd9, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 4'd3, 1'b0, 1'b0);
    idle_steps(4);

    step(1'b1, 4'd2, 1'b1, 1'b0);  idle_steps(8);

    step(1'b1, 4'd7, 1'b0, 1'b0);  idle_steps(4);
    step(1'b0, 4'd0, 1'b0, 1'b1);  idle_steps(12);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(3) == 0), WIDTH'($urandom), ($urandom_range(24) == 0),
           ($urandom_range(149) == 0));

`ifdef COUNTER_RUN_TIMEOUT_EN
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    freeze = 1'b1;
    step(1'b1, 4'd4, 1'b0, 1'b0);  idle_steps(14);
    step(1'b1, 4'd0, 1'b0, 1'b0);  idle_steps(6);
    freeze = 1'b0;
    step(1'b1, 4'd8, 1'b0, 1'b0);  idle_steps(14);
    step(1'b1, 4'd12, 1'b0, 1'b0); idle_steps(14);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
